// File: rtl/exec_ctrl_pkg.sv
// Shared types for the execution controller.
//   cmd_op_t     : host command encoding (3 bits)
//   ctrl_state_t : controller FSM states
//   op_ready()   : which commands the controller can take in a given state
//   sat_inc()    : saturating increment for the executed-instruction counter
package exec_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_WRITE     = 3'd1,
        OP_RUN       = 3'd2,
        OP_HALT      = 3'd3,
        OP_STEP      = 3'd4,
        OP_SET_BP    = 3'd5,
        OP_CLR_BP    = 3'd6,
        OP_RESET_CPU = 3'd7
    } cmd_op_t;

    typedef enum logic [1:0] {
        S_HALT   = 2'd0,
        S_RUN    = 2'd1,
        S_STEP   = 2'd2,
        S_CPURST = 2'd3
    } ctrl_state_t;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // While running, only commands that cannot disturb the executing program
    // are taken; everything else stalls until the CPU is halted.
    function automatic logic op_ready(input ctrl_state_t st, input cmd_op_t op);
        logic ok;
        case (st)
            S_HALT:  ok = 1'b1;
            S_RUN:   ok = (op == OP_NOP) || (op == OP_HALT) ||
                          (op == OP_SET_BP) || (op == OP_CLR_BP);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/exec_ctrl_prog_mem.sv
// Program memory: DEPTH x DATA_W, one synchronous write port, one
// asynchronous read port. Contents are deliberately not reset.
//   clock : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : mem[raddr], combinational
module exec_ctrl_prog_mem #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/exec_ctrl.sv
// Execution controller for the 4-bit CPU. Owns the program memory and its
// fetch port, and paces the CPU with a one-cycle clock-enable pulse and an
// active-low CPU reset. A host command port loads programs and provides
// run / halt / single-step / breakpoint control.
//   clock, reset          : single clock, synchronous active-high reset
//   cpu_addr / cpu_data   : CPU fetch port (async read of program memory)
//   cpu_en                : CPU executes one instruction in each cycle it is high
//   cpu_rst_n             : active-low CPU reset
//   cmd_valid/ready/op/addr/data : host command port
//   running, bp_hit       : status (bp_hit is sticky)
//   instr_cnt             : number of cpu_en pulses, saturating
//   dbg_state             : current FSM state (ctrl_state_t encoding)
//
// Command handshake: a command transfers on a rising edge where cmd_valid
// and cmd_ready are both high. cmd_ready depends only on the FSM state and
// cmd_op, never on cmd_valid, so the host may hold a command until taken.
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int RUN_DIV    = 4,
    parameter int RST_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_data,
    output logic              cpu_en,
    output logic              cpu_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              running,
    output logic              bp_hit,
    output logic [15:0]       instr_cnt,
    output logic [1:0]        dbg_state
);

    localparam int DIV_W = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
    localparam int RST_W = $clog2(RST_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

    ctrl_state_t       state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic              skip_bp_q, skip_bp_d;
    logic              bp_en_q, bp_en_d;
    logic [ADDR_W-1:0] bp_addr_q, bp_addr_d;
    logic              bp_hit_q, bp_hit_d;
    logic              cpu_en_q, cpu_en_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              running_q, running_d;
    logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;

    cmd_op_t op;
    logic    cmd_fire;
    logic    halt_fire;
    logic    div_last;
    logic    bp_match;
    logic    rst_last;

    assign op        = cmd_op_t'(cmd_op);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign halt_fire = cmd_fire && (op == OP_HALT);
    assign div_last  = (state_q == S_RUN) && (div_cnt_q == DIV_LAST);
    // skip_bp lets a run resumed at the breakpoint address execute that
    // instruction instead of stopping again immediately.
    assign bp_match  = bp_en_q && !skip_bp_q && (cpu_addr == bp_addr_q);
    assign rst_last  = (rst_cnt_q == RST_LAST);

    exec_ctrl_prog_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_prog_mem (
        .clock (clock),
        .we    (cmd_fire && (op == OP_WRITE)),
        .waddr (cmd_addr),
        .wdata (cmd_data),
        .raddr (cpu_addr),
        .rdata (cpu_data)
    );

    // State register (all controller flops).
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_CPURST;
            div_cnt_q   <= '0;
            rst_cnt_q   <= '0;
            skip_bp_q   <= 1'b0;
            bp_en_q     <= 1'b0;
            bp_addr_q   <= '0;
            bp_hit_q    <= 1'b0;
            cpu_en_q    <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            running_q   <= 1'b0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            rst_cnt_q   <= rst_cnt_d;
            skip_bp_q   <= skip_bp_d;
            bp_en_q     <= bp_en_d;
            bp_addr_q   <= bp_addr_d;
            bp_hit_q    <= bp_hit_d;
            cpu_en_q    <= cpu_en_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            running_q   <= running_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HALT: begin
                if (cmd_fire) begin
                    case (op)
                        OP_RUN:       state_d = S_RUN;
                        OP_STEP:      state_d = S_STEP;
                        OP_RESET_CPU: state_d = S_CPURST;
                        default:      state_d = S_HALT;
                    endcase
                end
            end
            S_RUN: begin
                // A host HALT and a breakpoint both stop before the pulse.
                if (halt_fire || (div_last && bp_match)) begin
                    state_d = S_HALT;
                end
            end
            S_STEP:   state_d = S_HALT;
            S_CPURST: if (rst_last) state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
    end

    // Datapath: divider, reset counter, breakpoint, pulse and counter.
    always_comb begin
        div_cnt_d   = '0;
        rst_cnt_d   = '0;
        cpu_en_d    = 1'b0;
        skip_bp_d   = skip_bp_q;
        bp_en_d     = bp_en_q;
        bp_addr_d   = bp_addr_q;
        bp_hit_d    = bp_hit_q;
        instr_cnt_d = cpu_en_q ? sat_inc(instr_cnt_q) : instr_cnt_q;

        if ((state_q == S_RUN) && (state_d == S_RUN)) begin
            div_cnt_d = div_last ? '0 : div_cnt_q + 1'b1;
        end
        if ((state_q == S_CPURST) && (state_d == S_CPURST)) begin
            rst_cnt_d = rst_cnt_q + 1'b1;
        end

        case (state_q)
            S_HALT: begin
                if (cmd_fire) begin
                    case (op)
                        OP_RUN: begin
                            skip_bp_d = 1'b1;
                            bp_hit_d  = 1'b0;
                        end
                        OP_STEP:      cpu_en_d    = 1'b1;
                        OP_RESET_CPU: instr_cnt_d = '0;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (div_last && !halt_fire) begin
                    if (bp_match) begin
                        bp_hit_d = 1'b1;
                    end else begin
                        cpu_en_d  = 1'b1;
                        skip_bp_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase

        if (cmd_fire && (op == OP_SET_BP)) begin
            bp_addr_d = cmd_addr;
            bp_en_d   = 1'b1;
        end
        if (cmd_fire && (op == OP_CLR_BP)) begin
            bp_en_d  = 1'b0;
            bp_hit_d = 1'b0;
        end

        cpu_rst_n_d = (state_d != S_CPURST);
        running_d   = (state_d == S_RUN);
    end

    // Outputs.
    always_comb begin
        cmd_ready = op_ready(state_q, op);
        cpu_en    = cpu_en_q;
        cpu_rst_n = cpu_rst_n_q;
        running   = running_q;
        bp_hit    = bp_hit_q;
        instr_cnt = instr_cnt_q;
        dbg_state = state_q;
    end

endmodule
